// File: rtl/nwc_output_streamer.sv
// nwc_output_streamer: ping-pong result buffer behind the INTT processor.
// Each frame is written as parallel lanes, one row per beat, into one of two
// banks. It is then serialised in coefficient order onto a single
// valid/ready stream while the other bank accepts the next frame.
//
// Handshake rules, both sides: a transfer happens on a rising edge where
// valid && ready. A producer never withdraws valid, and never changes data,
// until that transfer happens. in_ready depends only on bank state.
module nwc_output_streamer #(
  parameter int LOG_CORE_COUNT = 3,
  parameter int LOG_N          = 12,
  parameter int WORD_W         = 60,
  localparam int CORES         = 2 ** LOG_CORE_COUNT,
  localparam int LANES         = 2 * CORES,
  localparam int ROW_W         = LOG_N - LOG_CORE_COUNT - 2,
  localparam int HEIGHT        = 2 ** ROW_W,
  localparam int F             = 2 ** (LOG_N - 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROW_W-1:0]          in_addr,
  input  logic [LANES*WORD_W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_W-1:0]         out_data,
  output logic                      out_last,
  output logic [1:0]                frames_pending,
  output logic                      err_overflow
);

  localparam int IDX_W  = LOG_N - 1;
  localparam int LANE_W = LOG_CORE_COUNT + 1;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  // Bank state. r_wb is the write bank. r_ib is the bank that RAM reads are
  // issued from. r_rb is the bank whose words are leaving on out_*. r_ib
  // moves to the next bank as soon as the last read is issued. This lets the
  // next frame start streaming with no gap after word F-1.
  bank_state_e          r_bank [2];
  logic                 r_wb;
  logic                 r_ib;
  logic                 r_rb;
  logic [IDX_W-1:0]     r_issue_idx;
  logic                 r_issue_act;
  logic                 r_rd_vld;
  logic                 r_rd_last;
  logic [LANE_W-1:0]    r_rd_lane;
  logic [1:0]           r_pending;
  logic                 r_err;

  // Two-entry output buffer: the head drives the port, and the skid entry
  // absorbs the read that is in flight when the consumer stalls.
  logic                 r_out_valid;
  logic                 r_out_last;
  logic [WORD_W-1:0]    r_out_data;
  logic                 r_sk_valid;
  logic                 r_sk_last;
  logic [WORD_W-1:0]    r_sk_data;

  logic                 w_wr_accept;
  logic                 w_wr_done;
  logic                 w_pop;
  logic                 w_pop_last;
  logic [1:0]           w_occ;
  logic                 w_room;
  logic                 w_issue_ok;
  logic                 w_issue_last;
  logic                 w_half;
  logic [LOG_CORE_COUNT-1:0] w_core;
  logic [ROW_W-1:0]     w_row;
  logic [LANE_W-1:0]    w_lane;
  logic [WORD_W-1:0]    w_lane_q [LANES];
  logic [WORD_W-1:0]    w_rd_word;

  assign in_ready     = (r_bank[r_wb] == BANK_EMPTY) || (r_bank[r_wb] == BANK_FILLING);
  assign w_wr_accept  = in_valid && in_ready;
  assign w_wr_done    = w_wr_accept && (in_addr == ROW_W'(HEIGHT - 1));
  assign w_pop        = r_out_valid && out_ready;
  assign w_pop_last   = w_pop && r_out_last;

  // Words held or in flight. A new read is issued only if the result is
  // guaranteed a slot next cycle.
  assign w_occ        = 2'(r_out_valid) + 2'(r_sk_valid) + 2'(r_rd_vld);
  assign w_room       = (w_occ <= 2'd1) || ((w_occ == 2'd2) && w_pop);
  assign w_issue_ok   = w_room && ((r_bank[r_ib] == BANK_FULL) ||
                                   ((r_bank[r_ib] == BANK_DRAINING) && r_issue_act));
  assign w_issue_last = (r_issue_idx == IDX_W'(F - 1));

  // Coefficient order: the top bit picks the half, the next bits pick the
  // core, and the low bits pick the row.
  assign w_half       = r_issue_idx[LOG_N-2];
  assign w_core       = r_issue_idx[LOG_N-3 -: LOG_CORE_COUNT];
  assign w_row        = r_issue_idx[ROW_W-1:0];
  assign w_lane       = {w_core, w_half};

  // Each lane has its own RAM, covering both banks, with address {bank, row}.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [WORD_W-1:0] r_ram [2*HEIGHT];
    logic [WORD_W-1:0] r_q;
    // Write all lanes of an accepted beat; do a synchronous read for the issued word.
    always_ff @(posedge clk) begin
      if (w_wr_accept) r_ram[{r_wb, in_addr}] <= in_data[g*WORD_W +: WORD_W];
      if (w_issue_ok)  r_q <= r_ram[{r_ib, w_row}];
    end
    assign w_lane_q[g] = r_q;
  end

  assign w_rd_word = w_lane_q[r_rd_lane];

  // Bank state machine, pointers, read issue and frame accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank[0]   <= BANK_EMPTY;
      r_bank[1]   <= BANK_EMPTY;
      r_wb        <= 1'b0;
      r_ib        <= 1'b0;
      r_rb        <= 1'b0;
      r_issue_idx <= '0;
      r_issue_act <= 1'b0;
      r_rd_vld    <= 1'b0;
      r_rd_last   <= 1'b0;
      r_rd_lane   <= '0;
      r_pending   <= 2'd0;
      r_err       <= 1'b0;
    end else begin
      // The three transitions act on banks in distinct states, so they
      // never target the same bank in one cycle.
      if (w_wr_accept) begin
        r_bank[r_wb] <= w_wr_done ? BANK_FULL : BANK_FILLING;
        if (w_wr_done) r_wb <= ~r_wb;
      end
      if (w_issue_ok && (r_bank[r_ib] == BANK_FULL)) r_bank[r_ib] <= BANK_DRAINING;
      if (w_pop_last) begin
        r_bank[r_rb] <= BANK_EMPTY;
        r_rb         <= ~r_rb;
      end

      r_rd_vld <= w_issue_ok;
      if (w_issue_ok) begin
        r_rd_lane <= w_lane;
        r_rd_last <= w_issue_last;
        if (w_issue_last) begin
          r_issue_idx <= '0;
          r_issue_act <= 1'b0;
          r_ib        <= ~r_ib;
        end else begin
          r_issue_idx <= r_issue_idx + 1'b1;
          r_issue_act <= 1'b1;
        end
      end

      case ({w_wr_done, w_pop_last})
        2'b10:   r_pending <= r_pending + 2'd1;
        2'b01:   r_pending <= r_pending - 2'd1;
        default: r_pending <= r_pending;
      endcase

      if (in_valid && !in_ready) r_err <= 1'b1;
    end
  end

  // Output buffer: keep the head while stalled, otherwise refill it from skid or RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_sk_valid  <= 1'b0;
      r_sk_last   <= 1'b0;
      r_sk_data   <= '0;
    end else if (r_out_valid && !w_pop) begin
      if (!r_sk_valid) begin
        r_sk_valid <= r_rd_vld;
        r_sk_last  <= r_rd_last;
        r_sk_data  <= w_rd_word;
      end
    end else if (r_sk_valid) begin
      r_out_valid <= 1'b1;
      r_out_last  <= r_sk_last;
      r_out_data  <= r_sk_data;
      r_sk_valid  <= r_rd_vld;
      r_sk_last   <= r_rd_last;
      r_sk_data   <= w_rd_word;
    end else begin
      r_out_valid <= r_rd_vld;
      r_out_last  <= r_rd_vld && r_rd_last;
      if (r_rd_vld) r_out_data <= w_rd_word;
    end
  end

  assign out_valid      = r_out_valid;
  assign out_last       = r_out_last;
  assign out_data       = r_out_data;
  assign frames_pending = r_pending;
  assign err_overflow   = r_err;

endmodule

// File: tb/tb_nwc_output_streamer.sv
// tb_nwc_output_streamer: directed scenarios plus randomized frames. Every
// output is checked against a queue-based reference model of the streamer.
module tb_nwc_output_streamer;

  localparam int LCC    = 1;
  localparam int LN     = 6;
  localparam int WW     = 16;
  localparam int CORES  = 2 ** LCC;
  localparam int LANES  = 2 * CORES;
  localparam int ROW_W  = LN - LCC - 2;
  localparam int HEIGHT = 2 ** ROW_W;
  localparam int F      = 2 ** (LN - 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic                    in_valid;
  logic                    in_ready;
  logic [ROW_W-1:0]        in_addr;
  logic [LANES*WW-1:0]     in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [WW-1:0]           out_data;
  logic                    out_last;
  logic [1:0]              frames_pending;
  logic                    err_overflow;

  nwc_output_streamer #(.LOG_CORE_COUNT(LCC), .LOG_N(LN), .WORD_W(WW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_addr        (in_addr),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .frames_pending (frames_pending),
    .err_overflow   (err_overflow)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Bank contents persist across reset, as the RAM does. Expected words are
  // queued as {last, data} when a frame completes.
  logic [WW-1:0] m_mem [2][LANES][HEIGHT];
  logic          m_busy [2];
  int            m_wb;
  int            m_pending;
  logic          m_err;
  int            m_bank_q [$];
  logic [WW:0]   exp_q [$];

  int            pop_cnt = 0;
  int            cyc = 0;
  int            span_start_pop = -1;
  int            first_cyc = 0;
  int            last_cyc = 0;
  logic          prev_stall = 1'b0;
  logic [WW:0]   prev_word = '0;
  logic          bp_mode = 1'b0;

  task automatic model_reset();
    m_busy[0] = 1'b0;
    m_busy[1] = 1'b0;
    m_wb      = 0;
    m_pending = 0;
    m_err     = 1'b0;
    m_bank_q.delete();
    exp_q.delete();
  endtask

  // Push the F words of a completed bank in coefficient order.
  task automatic model_push_frame(input int b);
    int half, core, row, lane;
    for (int o = 0; o < F; o++) begin
      half = o / (F / 2);
      core = (o / HEIGHT) % CORES;
      row  = o % HEIGHT;
      lane = 2 * core + half;
      exp_q.push_back({(o == F - 1) ? 1'b1 : 1'b0, m_mem[b][lane][row]});
    end
  endtask

  // Monitor: sample on the falling edge and predict the next rising edge.
  always @(negedge clk) begin
    logic        rdy_now;
    logic [WW:0] w;
    int          b;
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      rdy_now = !m_busy[m_wb];
      check("in_ready", 64'(in_ready), 64'(rdy_now));
      check("frames_pending", 64'(frames_pending), 64'(m_pending));
      check("err_overflow", 64'(err_overflow), 64'(m_err));
      if (prev_stall) check("stall_hold", 64'({out_valid, out_last, out_data}), 64'({1'b1, prev_word}));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_valid_unexpected", 64'(out_valid), 64'(0));
        end else begin
          w = exp_q.pop_front();
          check("out_word", 64'({out_last, out_data}), 64'(w));
          if (w[WW]) begin
            b = m_bank_q.pop_front();
            m_busy[b] = 1'b0;
            m_pending--;
          end
        end
        if (pop_cnt == span_start_pop) first_cyc = cyc;
        last_cyc = cyc;
        pop_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_data};
      if (in_valid) begin
        if (rdy_now) begin
          for (int l = 0; l < LANES; l++) m_mem[m_wb][l][in_addr] = in_data[l*WW +: WW];
          if (in_addr == ROW_W'(HEIGHT - 1)) begin
            model_push_frame(m_wb);
            m_bank_q.push_back(m_wb);
            m_busy[m_wb] = 1'b1;
            m_pending++;
            m_wb = 1 - m_wb;
          end
        end else begin
          m_err = 1'b1;
        end
      end
    end
  end

  // Random 50% backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [LANES*WW-1:0] pat_row(input int f, input int r);
    logic [LANES*WW-1:0] d;
    for (int l = 0; l < LANES; l++) d[l*WW +: WW] = 16'((f << 12) | (l << 8) | (r << 4));
    return d;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_pending", 64'(frames_pending), 64'(0));
    check("rst_err", 64'(err_overflow), 64'(0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_beat(input int a, input logic [LANES*WW-1:0] d);
    in_valid = 1'b1;
    in_addr  = ROW_W'(a);
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_in_ready();
    int n = 0;
    while (!in_ready && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) check("in_ready_timeout", 64'(in_ready), 64'(1));
  endtask

  task automatic send_seq_frame(input int f);
    for (int r = 0; r < HEIGHT; r++) send_beat(r, pat_row(f, r));
  endtask

  task automatic send_random_frame();
    int nrows = $urandom_range(0, 10);
    for (int k = 0; k <= nrows; k++) begin
      wait_in_ready();
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_beat((k == nrows) ? HEIGHT - 1 : int'($urandom_range(0, HEIGHT - 2)),
                {$urandom, $urandom});
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", 64'(exp_q.size()), 64'(0));
    check("drain_out_valid", 64'(out_valid), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int base;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int l = 0; l < LANES; l++)
        for (int r = 0; r < HEIGHT; r++) m_mem[b][l][r] = '0;
    model_reset();
    #2;
    do_reset();

    // Single frame and its latency.
    out_ready = 1'b1;
    for (int r = 0; r < HEIGHT - 1; r++) send_beat(r, pat_row(0, r));
    send_beat(HEIGHT - 1, pat_row(0, HEIGHT - 1));
    check("lat_cycle0", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
    check("lat_cycle1", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
    check("lat_cycle2", 64'(out_valid), 64'(1));
    check("first_word", 64'({out_last, out_data}), 64'({1'b0, 16'h0000}));
    wait_drain(200);

    // Two frames back to back, with a contiguous 64-word output.
    span_start_pop = pop_cnt;
    base = pop_cnt;
    for (int r = 0; r < HEIGHT; r++) begin
      check("b2b_in_ready", 64'(in_ready), 64'(1));
      send_beat(r, pat_row(1, r));
    end
    for (int r = 0; r < HEIGHT; r++) begin
      check("b2b_in_ready", 64'(in_ready), 64'(1));
      send_beat(r, pat_row(2, r));
    end
    wait_drain(300);
    check("b2b_words", 64'(pop_cnt - base), 64'(2 * F));
    check("b2b_span", 64'(last_cyc - first_cyc + 1), 64'(2 * F));

    // Backpressure on a repeat of the first frame.
    bp_mode = 1'b1;
    base = pop_cnt;
    send_seq_frame(0);
    wait_drain(600);
    check("bp_words", 64'(pop_cnt - base), 64'(F));
    bp_mode = 1'b0;
    @(posedge clk);
    #1;

    // Overflow: two frames held, then a third beat is dropped.
    out_ready = 1'b0;
    send_seq_frame(4);
    send_seq_frame(5);
    check("ovf_in_ready", 64'(in_ready), 64'(0));
    check("ovf_err_before", 64'(err_overflow), 64'(0));
    send_beat(0, {$urandom, $urandom});
    check("ovf_err_after", 64'(err_overflow), 64'(1));
    out_ready = 1'b1;
    base = pop_cnt;
    wait_drain(300);
    check("ovf_words", 64'(pop_cnt - base), 64'(2 * F));

    // Reset after word 10 of a frame, then a fresh frame.
    send_seq_frame(6);
    base = pop_cnt;
    n = 0;
    while (pop_cnt < base + 11 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("mid_words_before_reset", 64'(pop_cnt - base), 64'(11));
    #2;
    do_reset();
    out_ready = 1'b1;
    base = pop_cnt;
    send_seq_frame(7);
    wait_drain(200);
    check("post_reset_words", 64'(pop_cnt - base), 64'(F));

    // Out-of-order writes: address 7 first completes the frame at once.
    send_beat(HEIGHT - 1, pat_row(8, HEIGHT - 1));
    check("ooo_pending", 64'(frames_pending), 64'(1));
    for (int r = 0; r < HEIGHT - 1; r++) send_beat(r, pat_row(8, r));
    check("ooo_second_bank_open", 64'(in_ready), 64'(1));
    send_beat(HEIGHT - 1, pat_row(9, HEIGHT - 1));
    wait_drain(300);

    // Randomized frames, gaps, row orders and backpressure.
    bp_mode = 1'b1;
    for (int k = 0; k < 6; k++) send_random_frame();
    wait_drain(1500);
    bp_mode = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nwc_output_streamer.md
# nwc_output_streamer

Parametrised, double-buffered result stage for the negacyclic-convolution datapath. It sits behind the INTT processor and captures each frame that the processor writes as parallel lanes, one row address per beat. It then serialises each frame onto a single valid/ready output stream in coefficient order. Ping-pong banking lets the next INTT frame be written while the previous one drains, and the output honours downstream backpressure.

## Interface
Parameters:
- LOG_CORE_COUNT, 3: log2 of butterfly cores (CORES = 2^LOG_CORE_COUNT; LANES = 2*CORES).
- LOG_N, 12: log2 of polynomial length. Frame length F = 2^(LOG_N-1) words.
- WORD_W, 60: bits per stored/output word (two packed coefficients at 60).
- Derived: ROW_W = LOG_N-LOG_CORE_COUNT-2; HEIGHT = 2^ROW_W rows per bank.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  write beat present.
- in_ready  out  1  a write bank is available.
- in_addr  in  ROW_W  row address of beat.
- in_data  in  LANES*WORD_W  lane L = 2*core+half at bits [(L+1)*WORD_W-1 : L*WORD_W].
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_data  out  WORD_W  serial word.
- out_last  out  1  high with word F-1 of a frame.
- frames_pending  out  2  count of completed, not-yet-fully-drained frames (0..2).
- err_overflow  out  1  sticky; write beat arrived with in_ready low.

## Operation
- Two banks, B0/B1, each LANES x HEIGHT x WORD_W in block RAM. Per-bank state is EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Write side:
  - The write pointer wb starts at B0.
  - A beat is accepted when in_valid && in_ready. Accepting it stores all lanes at in_addr in bank wb, and the bank enters FILLING if it was EMPTY.
  - An accepted beat with in_addr == HEIGHT-1 completes the frame. The bank goes to FULL, wb toggles, and frames_pending increments.
  - in_addr order is free. Rows are overwritten in place, and only address HEIGHT-1 ends a frame.
  - in_ready = (bank[wb] is EMPTY or FILLING).
  - A beat with in_valid && !in_ready is dropped and sets err_overflow. Only reset clears err_overflow.
- Read side:
  - The read pointer rb starts at B0. When bank[rb] is FULL it enters DRAINING, and the read counter o runs 0..F-1.
  - The word index decomposes as half = o[LOG_N-2], core = o[LOG_N-3 -: LOG_CORE_COUNT], row = o[ROW_W-1:0]. The emitted word is lane (2*core+half) at that row.
  - A 2-entry prefetch buffer covers the 1-cycle synchronous RAM read, so there are no bubbles while out_ready is high.
  - When word F-1 is accepted, the bank goes EMPTY, rb toggles, and frames_pending decrements.
- Simultaneous completion of one frame and final drain of the other in the same cycle: both transitions apply and frames_pending is unchanged.
- Reset mid-operation: both banks become EMPTY, wb = rb = B0, counters clear, and the prefetch buffer is flushed. RAM contents are not cleared. A partially streamed frame is abandoned, with no out_last.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_last = 0, out_data = 0, frames_pending = 0, err_overflow = 0.
- Latency: out_valid rises 2 cycles after the clock edge accepting the frame-completing beat, when the read side is idle.
- Throughput: 1 word per cycle while out_ready is high. A full frame takes F cycles.
- Back-to-back frames: word 0 of the next FULL bank follows word F-1 of the previous one with zero idle cycles.
- Handshake: with out_valid high and out_ready low, out_data and out_last hold stable and out_valid stays high. out_valid never drops without a transfer, except on reset.
- in_ready is combinational from bank state only, never from in_valid. It may fall in the cycle after a frame completes if the other bank is not EMPTY.
- err_overflow asserts the cycle after the offending beat.

## Test plan
Use LOG_CORE_COUNT=1, LOG_N=6, WORD_W=16, giving ROW_W=3, HEIGHT=8, LANES=4, F=32.
- Single frame, addresses 0..7, lane L at row r = 16'h{f,L,r}, out_ready = 1. Expect 32 words in order: lane0 rows 0..7, lane2, lane1, lane3 (word 8 = 16'h0200). out_last only on word 31. out_valid rises 2 cycles after the addr-7 beat.
- Two frames back-to-back with out_ready = 1. Expect 64 contiguous words with no gap, frames_pending 1->2->1->0, and in_ready never low.
- Backpressure: drive out_ready with a random 50% pattern. Expect data identical to the first scenario, out_data stable while stalled, and no word lost or duplicated.
- Overflow: complete 2 frames with out_ready = 0, then send a 3rd beat. Expect in_ready = 0, err_overflow = 1 the next cycle, and the first two frames to stream intact afterwards.
- Reset mid-stream: pulse rst_n low after word 10. Expect all outputs at reset values immediately (asynchronous). A new frame then streams from word 0 correctly.
- Out-of-order writes: send addresses 7,0,...,6 in that order. Expect the frame to complete on the first beat (addr 7), and the remaining beats to go to the other bank.
